// File: rtl/fifo_stream_out.sv
// Drains a registered-read FIFO into a valid/ready stream through a 2-entry skid buffer.
// Optional starvation counter on o_underruns, enabled by defining FIFO_STREAM_UNDERRUN_EN.
module fifo_stream_out #(
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          rst,
    output logic          o_rd,
    input  logic [DW-1:0] i_rdata,
    input  logic          i_rempty,
    output logic [DW-1:0] o_data,
    output logic          o_valid,
    input  logic          i_ready
`ifdef FIFO_STREAM_UNDERRUN_EN
    ,
    output logic [15:0]   o_underruns
`endif
);

    // Stream handshake: a sample transfers on a cycle with o_valid=1 and i_ready=1;
    // once o_valid is high, o_valid and o_data hold until that transfer happens.
    logic [1:0]    occ;
    logic          inflight;
    logic [DW-1:0] head;
    logic [DW-1:0] tail;
    logic          pop;
    logic [2:0]    level;
    logic [1:0]    kept;

    assign pop     = o_valid & i_ready;
    assign level   = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign kept    = occ - {1'b0, pop};
    assign o_rd    = rst & ~i_rempty & (level <= 3'd1);
    assign o_valid = (occ != 2'd0);
    assign o_data  = head;

    always_ff @(posedge clk) begin
        if (!rst) begin
            occ      <= 2'd0;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
        end else begin
            occ      <= level[1:0];
            inflight <= o_rd;
            if (pop) begin
                head <= tail;
            end
            // The returning sample lands behind whatever survives this cycle's pop.
            if (inflight) begin
                if (kept == 2'd0) begin
                    head <= i_rdata;
                end else begin
                    tail <= i_rdata;
                end
            end
        end
    end

`ifdef FIFO_STREAM_UNDERRUN_EN
    logic        primed;
    logic [15:0] underruns;

    always_ff @(posedge clk) begin
        if (!rst) begin
            primed    <= 1'b0;
            underruns <= 16'd0;
        end else begin
            if (pop) begin
                primed <= 1'b1;
            end
            if (i_ready && !o_valid && primed && (underruns != 16'hFFFF)) begin
                underruns <= underruns + 16'd1;
            end
        end
    end

    assign o_underruns = underruns;
`endif

endmodule

// File: tb/tb_fifo_stream_out.sv
// Bench for fifo_stream_out: FIFO model, randomized ready/writes, queue-based reference.
// Build with FIFO_STREAM_UNDERRUN_EN defined to also exercise the underrun counter.
module tb_fifo_stream_out;
    localparam int DW = 24;

    logic          clk;
    logic          rst;
    logic          o_rd;
    logic [DW-1:0] i_rdata;
    logic          i_rempty;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          i_ready;
`ifdef FIFO_STREAM_UNDERRUN_EN
    logic [15:0]   o_underruns;
`endif

    fifo_stream_out #(.DW(DW)) dut (
        .clk(clk),
        .rst(rst),
        .o_rd(o_rd),
        .i_rdata(i_rdata),
        .i_rempty(i_rempty),
        .o_data(o_data),
        .o_valid(o_valid),
        .i_ready(i_ready)
`ifdef FIFO_STREAM_UNDERRUN_EN
        ,
        .o_underruns(o_underruns)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference state: FIFO contents, samples owed to the stream, read accounting
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int outstanding = 0;
    bit rd_prev = 1'b0;
    bit rst_prev = 1'b0;
    int pops = 0;
    int first_rd = -1;
    int first_valid = -1;
    int first_pop = -1;
    int last_pop = -1;
`ifdef FIFO_STREAM_UNDERRUN_EN
    int und_m = 0;
    bit primed_m = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic fifo_write(input logic [DW-1:0] d);
        fifo_q.push_back(d);
        i_rempty = 1'b0;
    endtask

    task automatic clear_marks();
        first_rd = -1;
        first_valid = -1;
        first_pop = -1;
        last_pop = -1;
    endtask

    // One clock: check outputs at negedge, advance model and FIFO at posedge.
    task automatic step();
        bit exp_v;
        bit exp_rd;
        bit pop_m;
        logic [DW-1:0] rdat;
        @(negedge clk);
        cyc++;
        exp_v  = ((outstanding - int'(rd_prev)) != 0);
        pop_m  = exp_v && i_ready && rst;
        exp_rd = rst && (fifo_q.size() != 0) && ((outstanding - int'(exp_v && i_ready)) <= 1);
        check("rd", o_rd, exp_rd);
        check("valid", o_valid, exp_v);
        if (exp_v && exp_q.size() != 0) check("data", o_data, exp_q[0]);
        if (!rst_prev) check("rst_data", o_data, 0);
`ifdef FIFO_STREAM_UNDERRUN_EN
        check("underruns", o_underruns, und_m);
`endif
        if (exp_rd && first_rd < 0) first_rd = cyc;
        if (exp_v && first_valid < 0) first_valid = cyc;
        if (pop_m) begin
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        @(posedge clk);
`ifdef FIFO_STREAM_UNDERRUN_EN
        if (!rst) begin
            und_m = 0;
            primed_m = 1'b0;
        end else begin
            if (i_ready && !exp_v && primed_m && und_m < 65535) und_m++;
            if (pop_m) primed_m = 1'b1;
        end
`endif
        rdat = DW'($urandom);
        if (!rst) begin
            outstanding = 0;
            rd_prev = 1'b0;
            exp_q.delete();
        end else begin
            if (pop_m) begin
                void'(exp_q.pop_front());
                pops++;
                outstanding--;
            end
            if (exp_rd) begin
                rdat = fifo_q.pop_front();
                exp_q.push_back(rdat);
                outstanding++;
            end
            rd_prev = exp_rd;
        end
        rst_prev = rst;
        #1;
        i_rdata  = rdat;
        i_rempty = (fifo_q.size() == 0);
    endtask

    initial begin
        int p0;
        int n_wr;
        int bound;
        bit done;
        rst = 1'b0;
        i_ready = 1'b1;
        i_rdata = '0;
        i_rempty = 1'b1;
        for (int i = 1; i <= 8; i++) fifo_write(DW'(i));
        @(posedge clk);
        #1;

        // reset hold with data available and consumer ready
        for (int i = 0; i < 3; i++) step();

        // streaming of 1..8
        rst = 1'b1;
        clear_marks();
        p0 = pops;
        for (int i = 0; i < 14; i++) step();
        check("stream_latency", first_valid - first_rd, 2);
        check("stream_pops", pops - p0, 8);
        check("stream_back_to_back", last_pop - first_pop, 7);

        // back-pressure mid-stream
        p0 = pops;
        for (int i = 0; i < 12; i++) fifo_write(DW'(24'h100 + i));
        for (int i = 0; i < 4; i++) step();
        i_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_held", outstanding <= 2, 1);
        end
        i_ready = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("bp_pops", pops - p0, 12);

        // random ready and random FIFO fill over 1000 samples
        p0 = pops;
        n_wr = 0;
        bound = 0;
        done = 1'b0;
        while (!done && bound < 20000) begin
            if (n_wr < 1000 && $urandom_range(0, 9) < 6) begin
                fifo_write(DW'($urandom));
                n_wr++;
            end
            i_ready = $urandom_range(0, 1) != 0;
            step();
            bound++;
            if (pops - p0 == 1000) done = 1'b1;
        end
        check("rand_timeout", done, 1);
        check("rand_pops", pops - p0, 1000);
        check("rand_drained", exp_q.size(), 0);

        // reset in the cycle after a read issue
        i_ready = 1'b1;
        for (int i = 0; i < 6; i++) fifo_write(DW'(24'hA00 + i));
        bound = 0;
        while (first_rd < 0 || bound == 0) begin
            if (bound == 0) clear_marks();
            step();
            bound++;
            if (bound > 20) begin
                check("mid_rd_timeout", 0, 1);
                first_rd = 0;
            end
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("mid_after_rst_valid", o_valid, 0);
        for (int i = 0; i < 20; i++) step();
        check("mid_drained", exp_q.size(), 0);

`ifdef FIFO_STREAM_UNDERRUN_EN
        // starvation count after priming, then saturation
        begin
            int snap;
            i_ready = 1'b1;
            for (int i = 0; i < 4; i++) step();
            snap = und_m;
            for (int i = 0; i < 10; i++) step();
            @(negedge clk);
            check("und_plus10", o_underruns, snap + 10);
            @(posedge clk);
            #1;
            und_m = (und_m + 1 > 65535) ? 65535 : und_m + 1;
            for (int i = 0; i < 70000; i++) step();
            check("und_saturate", o_underruns, 16'hFFFF);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_stream_out.md
# fifo_stream_out

Drains the single-clock sample FIFO into a valid/ready stream for downstream DSP stages. It issues FIFO read strobes, absorbs the FIFO's one-cycle registered read latency in a 2-entry skid buffer, and sustains one sample per clock while the consumer is ready. It sits directly downstream of the FIFO: `o_rd`, `i_rdata` and `i_rempty` connect to the FIFO's read enable, read data and empty flag.

## Interface
- `DW`, 24, sample width in bits; matches the FIFO data width.
- `clk`  in  1  single clock, shared with the FIFO.
- `rst`  in  1  synchronous, active-low reset; `rst=0` at a rising `clk` edge resets the block.
- `o_rd`  out  1  FIFO read enable; combinational.
- `i_rdata`  in  DW  FIFO read data; valid the cycle after `o_rd=1`.
- `i_rempty`  in  1  FIFO (almost-)empty flag; registered, conservative.
- `o_data`  out  DW  stream sample.
- `o_valid`  out  1  stream valid.
- `i_ready`  in  1  stream ready from the consumer.
- `o_underruns`  out  16  starvation counter; present only with `FIFO_STREAM_UNDERRUN_EN`.

## Operation
- **State**
  - `occ`: buffer occupancy, 0..2.
  - `inflight`: 1 when a read was issued last cycle.
  - Two DW-bit entries in FIFO order; the head drives `o_data`.
- **Pop:** `pop = o_valid & i_ready`.
- **Read issue:** `o_rd = rst & ~i_rempty & ((occ + inflight - pop) <= 1)`.
  - At most one read per cycle.
  - The buffer never overflows.
- **Capture:** when `inflight=1`, `i_rdata` is written to the tail entry that cycle.
  - Capture and pop in the same cycle: `occ` is unchanged and the head advances.
  - Capture with `occ=0`: the sample becomes the head directly.
- **Valid:** `o_valid = (occ != 0)`.
  - `o_data` and `o_valid` hold stable while `o_valid=1` and `i_ready=0` (AXI-style: no retraction, no data change).
- **Reset:** `occ=0`, `inflight=0`, entries=0, `o_valid=0`, `o_data=0`, `o_rd=0`, `o_underruns=0`.
  - Reset mid-operation discards buffered samples.
  - Reset also discards any in-flight read: `i_rdata` in the cycle after reset release is not captured.
- **Empty-flag dependency:** the block trusts `i_rempty`.
  - The FIFO's almost-empty threshold covers the one-cycle lag of its registered flag.
  - The block adds no extra margin.
- **Arithmetic:** `occ + inflight - pop` is evaluated in 3 bits unsigned.
  - `pop` implies `occ >= 1`, so the expression never underflows.

## Timing
- **Latency:** `o_rd=1` in cycle N, `i_rdata` captured at the end of N+1, `o_valid=1` in N+2. Total: 2 cycles from read issue to sample presentation.
- **Steady state** (`i_ready=1`, FIFO not empty): `occ=1`, `inflight=1`, `o_rd=1` every cycle; one sample per clock.
- **Back-pressure:** `i_ready` low for k ≥ 2 cycles.
  - `o_rd` deasserts once `occ + inflight` reaches 2.
  - At most one further sample arrives; none is lost.
- **Recovery:** on `i_ready` rising with `occ=2`, `o_rd` reasserts in the same cycle (`occ + inflight - pop = 1`), restoring full rate with no bubble.
- **Simultaneous events:** capture, pop and issue may all occur in one cycle. Resulting state: `occ' = occ + inflight - pop`, `inflight' = o_rd`.
- **FIFO empty:** `o_rd=0`; in-flight and buffered samples still drain normally.

## Configuration
- Macro: `FIFO_STREAM_UNDERRUN_EN`.
- **Defined:**
  - A 16-bit counter `o_underruns` increments each cycle with `i_ready=1`, `o_valid=0` and `primed=1`.
  - `primed` sets on the first pop after reset.
  - The counter saturates at 0xFFFF and clears only on reset.
- **Undefined:** the port, counter and `primed` flag are absent; stream behaviour is identical.

## Test plan
- **Reset hold:** `rst=0` for 3 cycles with `i_rempty=0`, `i_ready=1` -> `o_rd=0`, `o_valid=0`, `o_data=0` throughout.
- **Streaming:** FIFO preloaded with 0x000001..0x000008, `i_ready=1` -> `o_valid` rises 2 cycles after the first `o_rd`, then 8 consecutive pops in order; `o_rd` drops when `i_rempty` asserts.
- **Back-pressure:** `i_ready=0` for 5 cycles mid-stream -> `o_data` is stable, at most 2 samples are held, no `o_rd` while `occ + inflight = 2`, no sample lost or duplicated after release.
- **Random ready** (50% duty) over 1000 samples -> the output sequence exactly equals the input sequence.
- **Mid-flight reset:** `rst=0` for 1 cycle in the cycle after an `o_rd` -> `o_valid=0` next cycle; the stale `i_rdata` never appears on `o_data`.
- **Underrun count** (`FIFO_STREAM_UNDERRUN_EN`): after the first pop, hold `i_rempty=1` with `i_ready=1` for 10 cycles once the buffer drains -> `o_underruns` increases by exactly 10; forcing 70000 such cycles -> `o_underruns` saturates at 0xFFFF.
